oclib_csr_arbiter: RTL and testbench

- Shares one CSR target bus (address/write/read/wdata out; rdata/ready/error back) between several requesters in a single clock domain.
- Round-robin arbitration over level-held requests, one transaction outstanding at a time.
- Per-transaction response timeout so a dead target cannot hang the bus.
- Sits between CSR masters (e.g. a synchronizer output, a debug port) and a shared CSR slave tree.

---
 rtl/oclib_csr_arbiter.sv | 154 +++++++++++++++
 tb/tb_oclib_csr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_csr_arbiter.sv
// Round-robin arbiter sharing one CSR target between several requesters,
// with one transaction in flight and a response timeout.

package oclib_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

endpackage

// state | meaning
// Idle  | no transaction; pick next requester round-robin from the pointer
// Wait  | request driven to target; waiting for ready/error or timeout
// Done  | response pulsed back; hold until the granted requester drops
module oclib_csr_arbiter #(
  parameter type CsrType       = oclib_pkg::csr_32_s,
  parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter int  Requesters    = 2,
  parameter int  TimeoutCycles = 1024,
  localparam int GrantW        = (Requesters > 1) ? $clog2(Requesters) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  CsrType            csrIn    [Requesters],
  output CsrFbType          csrInFb  [Requesters],
  output CsrType            csrOut,
  input  CsrFbType          csrOutFb,
  output logic [GrantW-1:0] csrGrant,
  output logic              csrBusy
);

  localparam int CountW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CountW-1:0] CountLast =
    (TimeoutCycles > 0) ? CountW'(TimeoutCycles - 1) : '0;
  localparam logic [GrantW-1:0] GrantLast = GrantW'(Requesters - 1);

  typedef enum logic [1:0] {
    Idle,
    Wait,
    Done
  } stateT;

  stateT                   state;
  logic [GrantW-1:0]       pointer;
  logic [GrantW-1:0]       selIdx;
  logic [GrantW-1:0]       nextPointer;
  logic [CountW-1:0]       count;
  logic [Requesters-1:0]   req;
  logic                    anyReq;
  logic                    timeoutHit;
  int                      idx;
  CsrFbType                fbQ [Requesters];

  always_comb begin
    for (int i = 0; i < Requesters; i++) begin
      req[i] = csrIn[i].read | csrIn[i].write;
    end
  end

  // Walk downward so the smallest offset from the pointer is the one that sticks.
  always_comb begin
    anyReq = 1'b0;
    selIdx = '0;
    idx    = 0;
    for (int k = Requesters - 1; k >= 0; k--) begin
      idx = (int'(pointer) + k) % Requesters;
      if (req[idx]) begin
        anyReq = 1'b1;
        selIdx = GrantW'(idx);
      end
    end
  end

  assign nextPointer = (csrGrant == GrantLast) ? '0 : csrGrant + 1'b1;
  assign timeoutHit  = (TimeoutCycles != 0) && (count == CountLast);
  assign csrBusy     = (state != Idle);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= Idle;
      csrOut   <= '0;
      csrGrant <= '0;
      pointer  <= '0;
      count    <= '0;
      for (int j = 0; j < Requesters; j++) begin
        fbQ[j] <= '0;
      end
    end else begin
      for (int j = 0; j < Requesters; j++) begin
        fbQ[j].ready <= 1'b0;
        fbQ[j].error <= 1'b0;
      end
      case (state)
        Idle: begin
          if (anyReq) begin
            csrOut.address <= csrIn[selIdx].address;
            csrOut.wdata   <= csrIn[selIdx].wdata;
            csrOut.read    <= csrIn[selIdx].read;
            csrOut.write   <= csrIn[selIdx].write;
            csrGrant       <= selIdx;
            count          <= '0;
            state          <= Wait;
          end
        end
        Wait: begin
          // A real response on the timeout cycle takes priority over the forced error.
          if (csrOutFb.ready || csrOutFb.error) begin
            csrOut.read            <= 1'b0;
            csrOut.write           <= 1'b0;
            fbQ[csrGrant].ready    <= csrOutFb.ready;
            fbQ[csrGrant].error    <= csrOutFb.error;
            fbQ[csrGrant].rdata    <= csrOutFb.rdata;
            state                  <= Done;
          end else if (timeoutHit) begin
            csrOut.read            <= 1'b0;
            csrOut.write           <= 1'b0;
            fbQ[csrGrant].error    <= 1'b1;
            fbQ[csrGrant].rdata    <= '0;
            state                  <= Done;
          end else begin
            count <= count + 1'b1;
          end
        end
        Done: begin
          pointer <= nextPointer;
          if (!req[csrGrant]) begin
            state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < Requesters; j++) begin
      csrInFb[j] = '0;
      if (GrantW'(j) == csrGrant) begin
        csrInFb[j] = fbQ[j];
      end
    end
  end

endmodule

// File: tb/tb_oclib_csr_arbiter.sv
// Scoreboard bench for oclib_csr_arbiter: directed requester/target stimulus,
// expected responses queued at issue time and checked by a pulse monitor.

module tb_oclib_csr_arbiter;
  import oclib_pkg::*;

  localparam int NReq = 2;
  localparam int Tmo  = 8;

  logic       clock = 1'b0;
  logic       reset;
  csr_32_s    csrIn    [NReq];
  csr_32_fb_s csrInFb  [NReq];
  csr_32_s    csrOut;
  csr_32_fb_s csrOutFb;
  logic [0:0] csrGrant;
  logic       csrBusy;

  csr_32_fb_s autoFb;
  csr_32_fb_s manualFb;
  logic       tgtEnable;
  logic       tgtErr;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } expT;

  expT sbQ[$];
  int  nCheck = 0;
  int  nPass  = 0;
  logic [31:0] addr [NReq];

  assign csrOutFb = tgtEnable ? autoFb : manualFb;

  always #5 clock = ~clock;

  oclib_csr_arbiter #(
    .CsrType      (csr_32_s),
    .CsrFbType    (csr_32_fb_s),
    .Requesters   (NReq),
    .TimeoutCycles(Tmo)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .csrIn   (csrIn),
    .csrInFb (csrInFb),
    .csrOut  (csrOut),
    .csrOutFb(csrOutFb),
    .csrGrant(csrGrant),
    .csrBusy (csrBusy)
  );

  function automatic logic [31:0] rdFn(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nCheck++;
    if (act === exp) nPass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic expectResp(int idx, logic [31:0] rd, logic rdy, logic err);
    expT e;
    e.idx   = idx;
    e.rdata = rd;
    e.ready = rdy;
    e.error = err;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitPulse(int maxCyc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < maxCyc && !seen; c++) begin
      @(negedge clock);
      if (csrInFb[0].ready || csrInFb[0].error || csrInFb[1].ready || csrInFb[1].error)
        seen = 1'b1;
    end
    if (!seen) begin
      nCheck++;
      $display("FAIL wait_pulse actual=no response required=response within %0d cycles", maxCyc);
    end
  endtask

  // Simple target: answers one cycle after it sees a read/write.
  always @(posedge clock) begin
    #1;
    if ((csrOut.read || csrOut.write) && !(autoFb.ready || autoFb.error)) begin
      autoFb.rdata = rdFn(csrOut.address);
      autoFb.ready = 1'b1;
      autoFb.error = tgtErr;
    end else begin
      autoFb = '0;
    end
  end

  always @(negedge clock) begin
    expT e;
    for (int j = 0; j < NReq; j++) begin
      if (j != int'(csrGrant) && csrInFb[j] !== '0) begin
        nCheck++;
        $display("FAIL nongrant_zero requester=%0d actual=%0h required=0", j, csrInFb[j]);
      end
      if (csrInFb[j].ready || csrInFb[j].error) begin
        if (sbQ.size() == 0) begin
          nCheck++;
          $display("FAIL unexpected_pulse requester=%0d actual=pulse required=none", j);
        end else begin
          e = sbQ.pop_front();
          check("resp_idx",   64'(j), 64'(e.idx));
          check("resp_rdata", 64'(csrInFb[j].rdata), 64'(e.rdata));
          check("resp_ready", 64'(csrInFb[j].ready), 64'(e.ready));
          check("resp_error", 64'(csrInFb[j].error), 64'(e.error));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    tgtEnable = 1'b0;
    tgtErr    = 1'b0;
    manualFb  = '0;
    autoFb    = '0;
    for (int j = 0; j < NReq; j++) csrIn[j] = '0;
    repeat (3) tick();
    @(negedge clock);
    check("rst_busy",  64'(csrBusy), 64'h0);
    check("rst_grant", 64'(csrGrant), 64'h0);
    check("rst_out",   64'(csrOut.read | csrOut.write), 64'h0);
    check("rst_addr",  64'(csrOut.address), 64'h0);
    check("rst_fb0",   64'(csrInFb[0]), 64'h0);
    check("rst_fb1",   64'(csrInFb[1]), 64'h0);
    tick();
    reset = 1'b0;

    // Both requesting from reset: 0 first, then alternate.
    tgtEnable = 1'b1;
    addr[0] = 32'h100;
    addr[1] = 32'h200;
    csrIn[0] = '{address: addr[0], write: 1'b0, read: 1'b1, wdata: 32'h0};
    csrIn[1] = '{address: addr[1], write: 1'b1, read: 1'b0, wdata: 32'h11};
    for (int n = 0; n < 6; n++) begin
      int g;
      g = n % 2;
      expectResp(g, rdFn(addr[g]), 1'b1, 1'b0);
      waitPulse(20);
      tick();
      csrIn[g] = '0;
      tick();
      addr[g] = addr[g] + 32'h4;
      if (n < 4) begin
        if (g == 0) csrIn[0] = '{address: addr[0], write: 1'b0, read: 1'b1, wdata: 32'h0};
        else        csrIn[1] = '{address: addr[1], write: 1'b1, read: 1'b0, wdata: 32'h11};
      end
    end
    repeat (2) tick();

    // Single read with hand-driven target.
    tgtEnable = 1'b0;
    csrIn[0] = '{address: 32'h10, write: 1'b0, read: 1'b1, wdata: 32'h0};
    @(negedge clock);
    check("sr_read_pre", 64'(csrOut.read), 64'h0);
    tick();
    @(negedge clock);
    check("sr_read_up", 64'(csrOut.read), 64'h1);
    check("sr_addr",    64'(csrOut.address), 64'h10);
    check("sr_grant",   64'(csrGrant), 64'h0);
    check("sr_busy",    64'(csrBusy), 64'h1);
    tick();
    tick();
    manualFb = '{rdata: 32'hDEADBEEF, ready: 1'b1, error: 1'b0};
    expectResp(0, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    manualFb = '0;
    @(negedge clock);
    check("sr_read_drop", 64'(csrOut.read), 64'h0);
    tick();
    csrIn[0] = '0;
    repeat (2) tick();
    @(negedge clock);
    check("sr_idle",       64'(csrBusy), 64'h0);
    check("sr_addr_hold",  64'(csrOut.address), 64'h10);
    check("sr_rdata_hold", 64'(csrInFb[0].rdata), 64'hDEADBEEF);
    check("sr_ready_low",  64'(csrInFb[0].ready), 64'h0);

    // Timeout on requester 1 (pointer now 1), then requester 0 served.
    tick();
    csrIn[1] = '{address: 32'h20, write: 1'b1, read: 1'b0, wdata: 32'h55AA};
    csrIn[0] = '{address: 32'h30, write: 1'b0, read: 1'b1, wdata: 32'h0};
    expectResp(1, 32'h0, 1'b0, 1'b1);
    tick();
    @(negedge clock);
    check("to_write_up", 64'(csrOut.write), 64'h1);
    check("to_grant",    64'(csrGrant), 64'h1);
    check("to_wdata",    64'(csrOut.wdata), 64'h55AA);
    repeat (Tmo - 1) tick();
    @(negedge clock);
    check("to_no_early", 64'(csrInFb[1].error), 64'h0);
    tick();
    @(negedge clock);
    check("to_err_pulse",  64'(csrInFb[1].error), 64'h1);
    check("to_write_drop", 64'(csrOut.write), 64'h0);
    tick();
    csrIn[1] = '0;
    tgtEnable = 1'b1;
    expectResp(0, rdFn(32'h30), 1'b1, 1'b0);
    waitPulse(20);
    tick();
    csrIn[0] = '0;
    repeat (2) tick();

    // Response arriving on the timeout cycle wins.
    tgtEnable = 1'b0;
    csrIn[1] = '{address: 32'h50, write: 1'b0, read: 1'b1, wdata: 32'h0};
    tick();
    repeat (Tmo - 1) tick();
    manualFb = '{rdata: 32'h12345678, ready: 1'b1, error: 1'b0};
    expectResp(1, 32'h12345678, 1'b1, 1'b0);
    tick();
    manualFb = '0;
    @(negedge clock);
    check("tc_no_forced_err", 64'(csrInFb[1].error), 64'h0);
    tick();
    csrIn[1] = '0;
    repeat (2) tick();

    // Error and ready together pass through.
    tgtEnable = 1'b1;
    tgtErr    = 1'b1;
    csrIn[0] = '{address: 32'h40, write: 1'b0, read: 1'b1, wdata: 32'h0};
    expectResp(0, rdFn(32'h40), 1'b1, 1'b1);
    waitPulse(20);
    tick();
    csrIn[0] = '0;
    tgtErr   = 1'b0;
    repeat (2) tick();

    // Reset mid-Wait (pointer is 1 before reset).
    tgtEnable = 1'b0;
    csrIn[0] = '{address: 32'h60, write: 1'b1, read: 1'b0, wdata: 32'hCAFE0001};
    tick();
    @(negedge clock);
    check("rw_write_up", 64'(csrOut.write), 64'h1);
    check("rw_wdata",    64'(csrOut.wdata), 64'hCAFE0001);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rw_out_rw",   64'(csrOut.read | csrOut.write), 64'h0);
    check("rw_out_addr", 64'(csrOut.address), 64'h0);
    check("rw_out_wd",   64'(csrOut.wdata), 64'h0);
    check("rw_busy",     64'(csrBusy), 64'h0);
    check("rw_fb0",      64'(csrInFb[0]), 64'h0);
    check("rw_fb1",      64'(csrInFb[1]), 64'h0);
    tick();
    reset    = 1'b0;
    csrIn[0] = '0;
    manualFb = '{rdata: 32'hBAD0BAD0, ready: 1'b1, error: 1'b0};
    tick();
    manualFb = '0;
    tick();
    @(negedge clock);
    check("rw_late_idle", 64'(csrBusy), 64'h0);
    tick();
    tgtEnable = 1'b1;
    csrIn[0] = '{address: 32'h70, write: 1'b0, read: 1'b1, wdata: 32'h0};
    csrIn[1] = '{address: 32'h80, write: 1'b0, read: 1'b1, wdata: 32'h0};
    expectResp(0, rdFn(32'h70), 1'b1, 1'b0);
    expectResp(1, rdFn(32'h80), 1'b1, 1'b0);
    waitPulse(20);
    tick();
    csrIn[0] = '0;
    waitPulse(20);
    tick();
    csrIn[1] = '0;
    repeat (2) tick();

    // Held request: no reissue while still asserted.
    csrIn[0] = '{address: 32'h90, write: 1'b0, read: 1'b1, wdata: 32'h0};
    expectResp(0, rdFn(32'h90), 1'b1, 1'b0);
    waitPulse(20);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      check("hold_no_reissue", 64'(csrOut.read), 64'h0);
      check("hold_busy",       64'(csrBusy), 64'h1);
    end
    tick();
    csrIn[0] = '0;
    repeat (2) tick();
    @(negedge clock);
    check("hold_idle", 64'(csrBusy), 64'h0);

    check("sb_empty", 64'(sbQ.size()), 64'h0);
    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
